// File: rtl/zeroriscy_imem_arbiter.sv
// Two-master arbiter sharing one req/gnt/rvalid memory port between the
// instruction fetch port (master I) and the load-store unit (master D).
// The granted master is held until its request is accepted, and an owner
// FIFO remembers who issued each outstanding transaction so every response
// is routed back to the right master. All handshake paths are combinational.
module zeroriscy_imem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 32'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 32'd1) ? $clog2(MAX_OUTSTANDING) : 32'd1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 32'd1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 32'd1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  // Owner encoding stored in the FIFO and in last_r.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_e;

  state_e                     state_r;
  logic                       last_r;
  logic [MAX_OUTSTANDING-1:0] owner_r;
  logic [PTR_W-1:0]           wptr_r;
  logic [PTR_W-1:0]           rptr_r;
  logic [CNT_W-1:0]           count_r;
  logic                       err_r;

  logic sel_d_s;
  logic sel_req_s;
  logic fifo_full_s;
  logic fifo_empty_s;
  logic stall_s;
  logic push_s;
  logic pop_s;
  logic head_owner_s;

  // Circular pointer advance; wraps at the FIFO depth, not the pointer width.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : (p + PTR_ONE);
  endfunction

  // Choose the master that owns the memory request channel this cycle.
  always_comb begin
    sel_d_s = OWNER_I;
    case (state_r)
      IDLE: begin
        if (instr_req_i && data_req_i) begin
          sel_d_s = (last_r == OWNER_I);
        end else if (data_req_i) begin
          sel_d_s = OWNER_D;
        end else begin
          sel_d_s = OWNER_I;
        end
      end
      LOCK_I:  sel_d_s = OWNER_I;
      LOCK_D:  sel_d_s = OWNER_D;
      default: sel_d_s = OWNER_I;
    endcase
  end

  assign fifo_full_s  = (count_r == CNT_FULL);
  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  // A response in the same cycle frees a slot, so a full FIFO only stalls without one.
  assign stall_s      = fifo_full_s & ~mem_rvalid_i;
  assign sel_req_s    = sel_d_s ? data_req_i : instr_req_i;
  assign push_s       = mem_req_o & mem_gnt_i;
  assign pop_s        = mem_rvalid_i & ~fifo_empty_s;
  assign head_owner_s = owner_r[rptr_r];

  assign mem_req_o   = sel_req_s & ~stall_s;
  assign mem_addr_o  = sel_d_s ? data_addr_i  : instr_addr_i;
  assign mem_we_o    = sel_d_s ? data_we_i    : 1'b0;
  assign mem_be_o    = sel_d_s ? data_be_i    : 4'hF;
  assign mem_wdata_o = sel_d_s ? data_wdata_i : 32'h0000_0000;

  assign instr_gnt_o = push_s & (sel_d_s == OWNER_I);
  assign data_gnt_o  = push_s & (sel_d_s == OWNER_D);

  assign instr_rvalid_o = pop_s & (head_owner_s == OWNER_I);
  assign data_rvalid_o  = pop_s & (head_owner_s == OWNER_D);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign busy_o = instr_req_i | data_req_i | ~fifo_empty_s;
  assign err_o  = err_r;

  // Ownership FSM and round-robin history for tie-breaking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      last_r  <= OWNER_D;
    end else begin
      if (push_s) begin
        last_r <= sel_d_s;
      end else begin
        last_r <= last_r;
      end
      if (!sel_req_s) begin
        // Nothing to hold (includes an illegal request drop while locked).
        state_r <= IDLE;
      end else if (mem_req_o && !mem_gnt_i) begin
        state_r <= sel_d_s ? LOCK_D : LOCK_I;
      end else if (mem_req_o) begin
        state_r <= IDLE;
      end else begin
        // Stalled on a full FIFO: keep whatever ownership we had.
        state_r <= state_r;
      end
    end
  end

  // Owner FIFO recording which master issued each outstanding transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= {MAX_OUTSTANDING{1'b0}};
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        owner_r[wptr_r] <= sel_d_s;
        wptr_r          <= ptr_inc(wptr_r);
      end else begin
        wptr_r <= wptr_r;
      end
      if (pop_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end else begin
        rptr_r <= rptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for a response that had no outstanding transaction to match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (mem_rvalid_i && fifo_empty_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_zeroriscy_imem_arbiter.sv
// Directed testbench for zeroriscy_imem_arbiter (MAX_OUTSTANDING = 2).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_zeroriscy_imem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        err_o;

  int checks;
  int errors;

  zeroriscy_imem_arbiter #(.MAX_OUTSTANDING(32'd2)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = 32'h0;
    data_req_i   = 1'b0;
    data_addr_i  = 32'h0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_wdata_i = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    checks++; if (instr_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_instr_gnt: got %b want 0", instr_gnt_o); end
    checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_data_gnt: got %b want 0", data_gnt_o); end
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_o); end
    @(negedge clk);
    instr_req_i = 1'b1;
    #1;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rst_mem_req_follow: got %b want 1", mem_req_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_busy_follow: got %b want 1", busy_o); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    do_reset();
    @(negedge clk);
    instr_req_i = 1'b1; instr_addr_i = 32'h80; mem_gnt_i = 1'b1;
    #1;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL fetch_mem_req: got %b want 1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h80) begin errors++; $display("FAIL fetch_addr: got %h want 00000080", mem_addr_o); end
    checks++; if ({mem_we_o, mem_be_o, mem_wdata_o} !== {1'b0, 4'hF, 32'h0}) begin errors++; $display("FAIL fetch_we_be_wdata: got %b %h %h want 0 f 0", mem_we_o, mem_be_o, mem_wdata_o); end
    checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin errors++; $display("FAIL fetch_gnt: got %b want 10", {instr_gnt_o, data_gnt_o}); end
    @(negedge clk);
    idle_inputs();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    #1;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL fetch_rvalid: got %b want 10", {instr_rvalid_o, data_rvalid_o}); end
    checks++; if (instr_rdata_o !== 32'h13) begin errors++; $display("FAIL fetch_rdata: got %h want 00000013", instr_rdata_o); end
    checks++; if (data_rdata_o !== 32'h13) begin errors++; $display("FAIL fetch_drdata: got %h want 00000013", data_rdata_o); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fetch_busy_end: got %b want 0", busy_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL fetch_err: got %b want 0", err_o); end
  endtask

  task automatic test_tie();
    logic [1:0] exp_gnt [0:4];
    logic [1:0] exp_rv  [0:4];
    exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01; exp_gnt[4] = 2'b00;
    exp_rv[0]  = 2'b00; exp_rv[1]  = 2'b10; exp_rv[2]  = 2'b01; exp_rv[3]  = 2'b10; exp_rv[4]  = 2'b01;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      instr_req_i = (c < 4); instr_addr_i = 32'h200;
      data_req_i = (c < 4); data_addr_i = 32'h300;
      data_we_i = 1'b1; data_be_i = 4'h3; data_wdata_i = 32'hDEAD_BEEF;
      mem_gnt_i = 1'b1;
      mem_rvalid_i = (c > 0); mem_rdata_i = 32'h1000 + c;
      #1;
      checks++; if ({instr_gnt_o, data_gnt_o} !== exp_gnt[c]) begin errors++; $display("FAIL tie_gnt[%0d]: got %b want %b", c, {instr_gnt_o, data_gnt_o}, exp_gnt[c]); end
      checks++; if ({instr_rvalid_o, data_rvalid_o} !== exp_rv[c]) begin errors++; $display("FAIL tie_rvalid[%0d]: got %b want %b", c, {instr_rvalid_o, data_rvalid_o}, exp_rv[c]); end
      if (exp_gnt[c] == 2'b01) begin
        checks++; if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {32'h300, 1'b1, 4'h3, 32'hDEAD_BEEF}) begin errors++; $display("FAIL tie_d_chan[%0d]: got %h %b %h %h", c, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o); end
      end else if (exp_gnt[c] == 2'b10) begin
        checks++; if ({mem_addr_o, mem_we_o, mem_be_o} !== {32'h200, 1'b0, 4'hF}) begin errors++; $display("FAIL tie_i_chan[%0d]: got %h %b %h", c, mem_addr_o, mem_we_o, mem_be_o); end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL tie_busy_end: got %b want 0", busy_o); end
  endtask

  task automatic test_lock();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      data_req_i = 1'b1; data_addr_i = 32'h100;
      instr_req_i = (c > 0); instr_addr_i = 32'h40 + 32'(c * 4);
      mem_gnt_i = (c == 3);
      #1;
      checks++; if (mem_addr_o !== 32'h100) begin errors++; $display("FAIL lock_addr[%0d]: got %h want 00000100", c, mem_addr_o); end
      checks++; if ({instr_gnt_o, data_gnt_o} !== ((c == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL lock_gnt[%0d]: got %b want %b", c, {instr_gnt_o, data_gnt_o}, (c == 3) ? 2'b01 : 2'b00); end
    end
    @(negedge clk);
    data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h50; mem_gnt_i = 1'b1;
    #1;
    checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin errors++; $display("FAIL lock_i_gnt: got %b want 10", {instr_gnt_o, data_gnt_o}); end
    checks++; if (mem_addr_o !== 32'h50) begin errors++; $display("FAIL lock_i_addr: got %h want 00000050", mem_addr_o); end
    @(negedge clk);
    idle_inputs();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA_0001;
    #1;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin errors++; $display("FAIL lock_rv_d: got %b want 01", {instr_rvalid_o, data_rvalid_o}); end
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA_0002;
    #1;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL lock_rv_i: got %b want 10", {instr_rvalid_o, data_rvalid_o}); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    instr_req_i = 1'b1; instr_addr_i = 32'h10; mem_gnt_i = 1'b1;
    @(negedge clk);
    instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h20;
    #1;
    checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL stall_fill_gnt: got %b want 1", data_gnt_o); end
    @(negedge clk);
    data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h14;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL stall_mem_req: got %b want 0", mem_req_o); end
    checks++; if (instr_gnt_o !== 1'b0) begin errors++; $display("FAIL stall_gnt: got %b want 0", instr_gnt_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy_o); end
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_0001;
    #1;
    checks++; if ({mem_req_o, instr_gnt_o} !== 2'b11) begin errors++; $display("FAIL stall_release: got %b want 11", {mem_req_o, instr_gnt_o}); end
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL stall_pop0: got %b want 10", {instr_rvalid_o, data_rvalid_o}); end
    @(negedge clk);
    instr_req_i = 1'b0; mem_gnt_i = 1'b0;
    #1;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin errors++; $display("FAIL stall_pop1: got %b want 01", {instr_rvalid_o, data_rvalid_o}); end
    @(negedge clk);
    #1;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL stall_pop2: got %b want 10", {instr_rvalid_o, data_rvalid_o}); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if ({busy_o, err_o} !== 2'b00) begin errors++; $display("FAIL stall_end: busy,err got %b want 00", {busy_o, err_o}); end
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    #1;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++; $display("FAIL spur_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %b want 1", err_o); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err_sticky: got %b want 1", err_o); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL spur_err_clear: got %b want 0", err_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    instr_req_i = 1'b1; instr_addr_i = 32'h400; mem_gnt_i = 1'b1;
    @(negedge clk);
    instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h404;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy_o); end
    @(negedge clk);
    rst_n = 1'b1;
    data_req_i = 1'b1; data_addr_i = 32'h500; mem_gnt_i = 1'b1;
    #1;
    checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin errors++; $display("FAIL mid_gnt: got %b want 01", {instr_gnt_o, data_gnt_o}); end
    @(negedge clk);
    idle_inputs();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D;
    #1;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin errors++; $display("FAIL mid_route: got %b want 01", {instr_rvalid_o, data_rvalid_o}); end
    checks++; if (data_rdata_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL mid_rdata: got %h want 0badf00d", data_rdata_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mid_err_clean: got %b want 0", err_o); end
    @(negedge clk);
    #1;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++; $display("FAIL mid_stale: got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL mid_err_late: got %b want 1", err_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_tie();
    test_lock();
    test_stall();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
